// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU for the softcore execute stage.
//   ADD/SUB/AND/OR/XOR/SLT/SLTU complete in one cycle. SLL/SRL/SRA shift one bit per
//   cycle, and MUL is a shift-add multiplier that also handles one bit per cycle. Only one
//   operation is in flight at a time. The result and flags stay registered until the
//   consumer takes them.
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (in_ready only in IDLE)
//   a, b, alu_control    operands and 4-bit opcode, captured on accept
//   out_valid/out_ready  result handshake (out_valid only in DONE)
//   result, zero, carry, overflow   registered result and flags
//   busy                 high whenever the block is not IDLE
module alu_mc #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned MUL_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       alu_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             carry,
    output logic             overflow,
    output logic             busy
);

    localparam int unsigned SH_W  = $clog2(WIDTH);
    localparam int unsigned CNT_W = SH_W + 1;  // must hold WIDTH for MUL

    localparam logic [3:0] OpAdd  = 4'b0000;
    localparam logic [3:0] OpSub  = 4'b0001;
    localparam logic [3:0] OpSltu = 4'b0010;
    localparam logic [3:0] OpOr   = 4'b0011;
    localparam logic [3:0] OpXor  = 4'b0100;
    localparam logic [3:0] OpSlt  = 4'b0101;
    localparam logic [3:0] OpAnd  = 4'b0111;
    localparam logic [3:0] OpSll  = 4'b1000;
    localparam logic [3:0] OpSrl  = 4'b1001;
    localparam logic [3:0] OpSra  = 4'b1010;
    localparam logic [3:0] OpMul  = 4'b1011;

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e             state_q, state_d;
    logic [3:0]         op_q, op_d;
    logic [WIDTH-1:0]   work_q, work_d;      // shift operand, or MUL multiplicand
    logic [WIDTH-1:0]   mplier_q, mplier_d;  // MUL multiplier, consumed LSB first
    logic [WIDTH-1:0]   acc_q, acc_d;        // MUL partial product
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               carry_q, carry_d;
    logic               ovf_q, ovf_d;

    // Single-cycle datapath, evaluated on the live inputs during IDLE
    logic [WIDTH:0]     sum_ext;
    logic [WIDTH:0]     diff_ext;
    logic [WIDTH-1:0]   sc_res;
    logic               sc_carry;
    logic               sc_ovf;
    logic               is_shift;
    logic [SH_W-1:0]    shamt;
    logic [WIDTH-1:0]   step_res;

    assign shamt    = b[SH_W-1:0];
    assign is_shift = (alu_control == OpSll) || (alu_control == OpSrl) ||
                      (alu_control == OpSra);
    assign sum_ext  = {1'b0, a} + {1'b0, b};
    assign diff_ext = {1'b0, a} - {1'b0, b};

    always_comb begin
        sc_res   = '0;
        sc_carry = 1'b0;
        sc_ovf   = 1'b0;
        case (alu_control)
            OpAdd: begin
                sc_res   = sum_ext[WIDTH-1:0];
                sc_carry = sum_ext[WIDTH];
                sc_ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OpSub: begin
                sc_res   = diff_ext[WIDTH-1:0];
                sc_carry = ~diff_ext[WIDTH];  // no borrow means a >= b
                sc_ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (diff_ext[WIDTH-1] != a[WIDTH-1]);
            end
            OpAnd:  sc_res = a & b;
            OpOr:   sc_res = a | b;
            OpXor:  sc_res = a ^ b;
            OpSlt:  sc_res = WIDTH'($signed(a) < $signed(b));
            OpSltu: sc_res = WIDTH'(a < b);
            // A shift by zero finishes here with the operand unchanged
            OpSll, OpSrl, OpSra: sc_res = a;
            default: sc_res = '0;  // also MUL when the multiplier is not built
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        work_d   = work_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        zero_d   = zero_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        step_res = '0;

        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    op_d = alu_control;
                    if (is_shift && (shamt != '0)) begin
                        work_d  = a;
                        cnt_d   = CNT_W'(shamt);
                        state_d = StBusy;
                    end else if ((alu_control == OpMul) && (MUL_EN != 0)) begin
                        work_d   = a;
                        mplier_d = b;
                        acc_d    = '0;
                        cnt_d    = CNT_W'(WIDTH);
                        state_d  = StBusy;
                    end else begin
                        result_d = sc_res;
                        zero_d   = (sc_res == '0);
                        carry_d  = sc_carry;
                        ovf_d    = sc_ovf;
                        state_d  = StDone;
                    end
                end
            end
            StBusy: begin
                cnt_d = cnt_q - CNT_W'(1);
                case (op_q)
                    OpMul: begin
                        acc_d    = acc_q + (mplier_q[0] ? work_q : '0);
                        work_d   = work_q << 1;
                        mplier_d = mplier_q >> 1;
                        step_res = acc_d;
                    end
                    OpSll: begin
                        work_d   = work_q << 1;
                        step_res = work_d;
                    end
                    OpSrl: begin
                        work_d   = work_q >> 1;
                        step_res = work_d;
                    end
                    default: begin
                        // SRA: the top bit is the captured sign and is never overwritten
                        work_d   = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
                        step_res = work_d;
                    end
                endcase
                if (cnt_q == CNT_W'(1)) begin
                    result_d = step_res;
                    zero_d   = (step_res == '0);
                    carry_d  = 1'b0;
                    ovf_d    = 1'b0;
                    state_d  = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            op_q     <= '0;
            work_q   <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            work_q   <= work_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign result    = result_q;
    assign zero      = zero_q;
    assign carry     = carry_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: randomized and directed self-checking bench for alu_mc (WIDTH=32, MUL_EN=1).
// Expected values come from an arithmetic reference model of the opcode table.
module tb_alu_mc;

    localparam int unsigned W = 32;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   alu_control;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         carry;
    logic         overflow;
    logic         busy;

    int checks = 0;
    int errors = 0;

    alu_mc #(
        .WIDTH (W),
        .MUL_EN(1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .a          (a),
        .b          (b),
        .alu_control(alu_control),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero),
        .carry      (carry),
        .overflow   (overflow),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: behaviour straight from the opcode table
    function automatic void model(input logic [3:0] op, input logic [W-1:0] x,
                                  input logic [W-1:0] y, output logic [W-1:0] res,
                                  output logic z, output logic c, output logic v,
                                  output int lat);
        longint sx = longint'($signed(x));
        longint sy = longint'($signed(y));
        longint s;
        longint unsigned ux = 64'(x);
        longint unsigned uy = 64'(y);
        longint unsigned p;
        int n = int'(y[4:0]);
        res = '0;
        c   = 1'b0;
        v   = 1'b0;
        lat = 1;
        case (op)
            4'b0000: begin
                p   = ux + uy;
                res = p[W-1:0];
                c   = (p >= 64'h1_0000_0000);
                s   = sx + sy;
                v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0001: begin
                res = x - y;
                c   = (x >= y);
                s   = sx - sy;
                v   = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'b0111: res = x & y;
            4'b0011: res = x | y;
            4'b0100: res = x ^ y;
            4'b0101: res = (sx < sy) ? 32'd1 : 32'd0;
            4'b0010: res = (ux < uy) ? 32'd1 : 32'd0;
            4'b1000: begin res = x << n;                 lat = n + 1; end
            4'b1001: begin res = x >> n;                 lat = n + 1; end
            4'b1010: begin res = W'($signed(x) >>> n);   lat = n + 1; end
            4'b1011: begin
                p   = ux * uy;
                res = p[W-1:0];
                lat = W + 1;
            end
            default: res = '0;
        endcase
        z = (res == '0);
    endfunction

    // Issue one operation, check result/flags/latency against the model, then release it.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] x,
                          input logic [W-1:0] y, output logic [W-1:0] got);
        logic [W-1:0] e_res;
        logic e_z, e_c, e_v;
        int e_lat;
        int lat;
        model(op, x, y, e_res, e_z, e_c, e_v, e_lat);
        @(negedge clk);
        check({tag, "_in_ready"}, 64'(in_ready), 64'd1);
        alu_control = op;
        a           = x;
        b           = y;
        in_valid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid    = 1'b0;
        a           = $urandom;  // later operand changes must not matter
        b           = $urandom;
        alu_control = 4'($urandom);
        if (e_lat > 1) begin
            check({tag, "_busy"}, {61'd0, busy, in_ready, out_valid}, 64'b100);
        end
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(e_lat));
        check({tag, "_result"}, 64'(result), 64'(e_res));
        check({tag, "_flags"}, {61'd0, zero, carry, overflow}, {61'd0, e_z, e_c, e_v});
        got = result;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_released"}, 64'(out_valid), 64'd0);
    endtask

    logic [W-1:0] r;
    logic [W-1:0] held;
    logic [3:0]   ops [11];

    initial begin
        ops = '{4'b0000, 4'b0001, 4'b0111, 4'b0011, 4'b0101, 4'b0100,
                4'b0010, 4'b1000, 4'b1001, 4'b1010, 4'b1011};
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        a           = '0;
        b           = '0;
        alu_control = '0;
        #1;
        check("reset_outputs", {58'd0, result == '0, zero, carry, overflow, out_valid, busy},
              64'b100000);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_op("add_wrap", 4'b0000, 32'hFFFF_FFFF, 32'd1, r);
        check("add_wrap_const", {31'd0, r, zero, carry, overflow}, {31'd0, 32'd0, 3'b110});
        run_op("sub_ovf", 4'b0001, 32'h8000_0000, 32'd1, r);
        check("sub_ovf_const", {31'd0, r, carry, overflow}, {31'd0, 32'h7FFF_FFFF, 2'b11});
        run_op("slt", 4'b0101, 32'hFFFF_FFFF, 32'd1, r);
        check("slt_const", 64'(r), 64'd1);
        run_op("sltu", 4'b0010, 32'hFFFF_FFFF, 32'd1, r);
        check("sltu_const", 64'(r), 64'd0);
        run_op("sra31", 4'b1010, 32'h8000_0000, 32'h1F, r);
        check("sra31_const", 64'(r), 64'hFFFF_FFFF);
        run_op("sll0", 4'b1000, 32'h1234_5678, 32'h20, r);
        check("sll0_const", 64'(r), 64'h1234_5678);
        run_op("mul", 4'b1011, 32'h0001_0003, 32'h0000_0005, r);
        check("mul_const", 64'(r), 64'h0005_000F);
        run_op("undef", 4'b1111, 32'hDEAD_BEEF, 32'h1, r);

        // Randomized: all 16 codes, with shift amounts spread over the full range
        for (int i = 0; i < 60; i++) begin
            logic [3:0] op;
            op = (i % 4 == 3) ? 4'($urandom_range(0, 15)) : ops[$urandom_range(0, 10)];
            run_op($sformatf("rnd%0d", i), op, $urandom, $urandom, r);
        end

        // Back-pressure: result held in DONE, new requests ignored
        @(negedge clk);
        alu_control = 4'b0001;
        a           = 32'd9;
        b           = 32'd2;
        in_valid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        alu_control = 4'b0000;
        a           = 32'd7;
        b           = 32'd8;
        held        = result;
        check("bp_first", 64'(held), 64'd7);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold", {29'd0, result, out_valid, in_ready, carry},
                  {29'd0, 32'd7, 1'b1, 1'b0, 1'b1});
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_idle", {62'd0, in_ready, out_valid}, 64'b10);
        @(negedge clk);
        in_valid = 1'b0;
        check("bp_next", {31'd0, out_valid, result}, {31'd0, 1'b1, 32'd15});
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        // Reset in the middle of a multiply
        run_op("pre_rst", 4'b0001, 32'd9, 32'd2, r);  // leaves result 7, carry 1
        @(negedge clk);
        alu_control = 4'b1011;
        a           = 32'h1234;
        b           = 32'h5678;
        in_valid    = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_mul_busy", 64'(busy), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_outputs", {58'd0, result == '0, zero, carry, overflow, out_valid, busy},
              64'b100000);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("post_rst", 4'b0000, 32'd2, 32'd3, r);
        check("post_rst_const", 64'(r), 64'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute guard against a hung run
    initial begin
        #500000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
